// File: rtl/frng_arb_pkg.sv
// rtl/frng_arb_pkg.sv - shared types and constants for the fringe put arbiter
package frng_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } arb_state_e;

    localparam int DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

    // Saturating add of a small increment onto the drop counter.
    function automatic logic [DROP_CNT_W-1:0] drop_sat_add(
        input logic [DROP_CNT_W-1:0] cnt,
        input logic [7:0]            inc
    );
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, cnt} + (DROP_CNT_W+1)'(inc);
        return sum[DROP_CNT_W] ? DROP_CNT_MAX : sum[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/frng_rr_pick.sv
// rtl/frng_rr_pick.sv - combinational round-robin priority select
module frng_rr_pick #(
    parameter int N_REQ = 4,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    always_comb begin
        int   cand;
        logic found;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req[cand]) begin
                grant_idx = IDX_W'(cand);
                found     = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/frng_put_arbiter.sv
// rtl/frng_put_arbiter.sv - latest-wins round-robin scheduler onto the fringe put port
module frng_put_arbiter
    import frng_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int SIG_IDX_W = 8,
    parameter int DATA_W    = 32,
    localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        i_clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_W-1:0]     req_data,
    input  logic [N_REQ*SIG_IDX_W-1:0]  req_sig_idx,
    output logic [N_REQ-1:0]            pending,
    output logic                        put_valid,
    input  logic                        put_ready,
    output logic [SIG_IDX_W-1:0]        put_sig_idx,
    output logic [DATA_W-1:0]           put_data,
    output logic [IDX_W-1:0]            put_src,
    output logic [DROP_CNT_W-1:0]       drop_cnt
);

    arb_state_e             state_q;
    logic [N_REQ-1:0]       pending_q, pending_d;
    logic [DATA_W-1:0]      pend_data_q [N_REQ];
    logic [SIG_IDX_W-1:0]   pend_idx_q  [N_REQ];
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   put_valid_q;
    logic [SIG_IDX_W-1:0]   put_sig_idx_q;
    logic [DATA_W-1:0]      put_data_q;
    logic [IDX_W-1:0]       put_src_q;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic                   accept;
    logic                   load;
    logic [IDX_W-1:0]       pick_ptr;
    logic [IDX_W-1:0]       grant_idx;
    logic                   any_pend;
    logic [7:0]             drop_inc;

    // On acceptance the pointer advances before picking, so back-to-back
    // loads already see the rotated priority.
    always_comb begin
        accept   = put_valid_q && put_ready;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (put_src_q == IDX_W'(N_REQ - 1)) ? '0 : put_src_q + IDX_W'(1);
        end
        pick_ptr = rr_ptr_d;
    end

    frng_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req       (pending_q),
        .rr_ptr    (pick_ptr),
        .grant_idx (grant_idx),
        .any       (any_pend)
    );

    always_comb begin
        logic clr;
        load      = enable && any_pend && (state_q == ARB_IDLE || accept);
        pending_d = pending_q;
        drop_inc  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            clr          = load && (grant_idx == IDX_W'(i));
            pending_d[i] = req_valid[i] | (pending_q[i] & ~clr);
            if (req_valid[i] && pending_q[i] && !clr) begin
                drop_inc = drop_inc + 8'd1;
            end
        end
        drop_cnt_d = drop_sat_add(drop_cnt_q, drop_inc);
    end

    always_ff @(posedge i_clk) begin
        if (!reset_n) begin
            state_q       <= ARB_IDLE;
            pending_q     <= '0;
            rr_ptr_q      <= '0;
            put_valid_q   <= 1'b0;
            put_sig_idx_q <= '0;
            put_data_q    <= '0;
            put_src_q     <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_cnt_q <= drop_cnt_d;
            if (load) begin
                state_q       <= ARB_OFFER;
                put_valid_q   <= 1'b1;
                put_src_q     <= grant_idx;
                put_data_q    <= pend_data_q[grant_idx];
                put_sig_idx_q <= pend_idx_q[grant_idx];
            end else if (accept) begin
                state_q     <= ARB_IDLE;
                put_valid_q <= 1'b0;
            end
        end
    end

    // Storage needs no reset: pending_q qualifies every entry.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i]) begin
                pend_data_q[i] <= req_data[i*DATA_W +: DATA_W];
                pend_idx_q[i]  <= req_sig_idx[i*SIG_IDX_W +: SIG_IDX_W];
            end
        end
    end

    assign pending     = pending_q;
    assign put_valid   = put_valid_q;
    assign put_sig_idx = put_sig_idx_q;
    assign put_data    = put_data_q;
    assign put_src     = put_src_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_frng_put_arbiter.sv
// tb/tb_frng_put_arbiter.sv - self-checking bench for frng_put_arbiter
module tb_frng_put_arbiter;

    localparam int N = 4;
    localparam int SW = 8;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [N-1:0]    rv;
    logic [N*DW-1:0] rdata;
    logic [N*SW-1:0] ridx;
    logic [N-1:0]    pend;
    logic            pvalid;
    logic            prdy;
    logic [SW-1:0]   psidx;
    logic [DW-1:0]   pdata;
    logic [1:0]      psrc;
    logic [15:0]     dcnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    frng_put_arbiter #(.N_REQ(N), .SIG_IDX_W(SW), .DATA_W(DW)) dut (
        .i_clk(clk), .reset_n(rst_n), .enable(en),
        .req_valid(rv), .req_data(rdata), .req_sig_idx(ridx),
        .pending(pend), .put_valid(pvalid), .put_ready(prdy),
        .put_sig_idx(psidx), .put_data(pdata), .put_src(psrc), .drop_cnt(dcnt)
    );

    // Reference model: per-requester mailboxes plus one offer slot.
    logic [DW-1:0] m_val [N];
    logic [SW-1:0] m_idx [N];
    bit            m_pend [N];
    int            m_rr, m_src, m_drop;
    bit            m_valid;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_sidx;

    task automatic model_step();
        bit acc, anyp;
        int w;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            m_rr = 0; m_src = 0; m_drop = 0; m_valid = 0; m_data = '0; m_sidx = '0;
            return;
        end
        acc = m_valid && prdy;
        if (acc) m_rr = (m_src + 1) % N;
        anyp = 0;
        for (int i = 0; i < N; i++) anyp |= m_pend[i];
        if (en && anyp && (!m_valid || acc)) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && m_pend[(m_rr + k) % N]) w = (m_rr + k) % N;
            m_src = w; m_data = m_val[w]; m_sidx = m_idx[w];
            m_pend[w] = 0; m_valid = 1;
        end else if (acc) begin
            m_valid = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (rv[i]) begin
                if (m_pend[i]) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
                m_val[i] = rdata[i*DW +: DW];
                m_idx[i] = ridx[i*SW +: SW];
                m_pend[i] = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [N-1:0] mp;
        for (int i = 0; i < N; i++) mp[i] = m_pend[i];
        chk("model pending", 64'(pend), 64'(mp));
        chk("model put_valid", 64'(pvalid), 64'(m_valid));
        chk("model put_src", 64'(psrc), 64'(m_src));
        chk("model put_data", 64'(pdata), 64'(m_data));
        chk("model put_sig_idx", 64'(psidx), 64'(m_sidx));
        chk("model drop_cnt", 64'(dcnt), 64'(m_drop));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic drive(input bit r, input bit e, input logic [N-1:0] v,
                         input logic [DW-1:0] d, input logic [SW-1:0] x, input bit rd);
        rst_n = r; en = e; rv = v; rdata = {N{d}}; ridx = {N{x}}; prdy = rd;
    endtask

    typedef struct {
        bit rst; bit en; logic [3:0] rv; logic [31:0] d; logic [7:0] idx; bit rdy;
        bit e_valid; int e_src; logic [31:0] e_data; logic [7:0] e_idx; logic [3:0] e_pend;
    } vec_t;

    vec_t tv [22];

    initial begin
        logic [DW-1:0] first_val;
        drive(0, 1, '0, '0, '0, 0);
        for (int i = 0; i < N; i++) begin m_val[i] = '0; m_idx[i] = '0; m_pend[i] = 0; end

        tv[0]  = '{0,1,4'h0,32'h00,8'h00,0, 0,0,32'h00,8'h00,4'h0};
        tv[1]  = '{1,1,4'h2,32'h01,8'h05,1, 0,0,32'h00,8'h00,4'h2};
        tv[2]  = '{1,1,4'h0,32'h00,8'h00,1, 1,1,32'h01,8'h05,4'h0};
        tv[3]  = '{1,1,4'h0,32'h00,8'h00,1, 0,0,32'h00,8'h00,4'h0};
        tv[4]  = '{0,1,4'h0,32'h00,8'h00,1, 0,0,32'h00,8'h00,4'h0};
        tv[5]  = '{1,1,4'hF,32'h10,8'h20,1, 0,0,32'h00,8'h00,4'hF};
        tv[6]  = '{1,1,4'h0,32'h00,8'h00,1, 1,0,32'h10,8'h20,4'hE};
        tv[7]  = '{1,1,4'h0,32'h00,8'h00,1, 1,1,32'h10,8'h20,4'hC};
        tv[8]  = '{1,1,4'h0,32'h00,8'h00,1, 1,2,32'h10,8'h20,4'h8};
        tv[9]  = '{1,1,4'h0,32'h00,8'h00,1, 1,3,32'h10,8'h20,4'h0};
        tv[10] = '{1,1,4'h0,32'h00,8'h00,1, 0,0,32'h00,8'h00,4'h0};
        tv[11] = '{1,0,4'h7,32'h30,8'h40,1, 0,0,32'h00,8'h00,4'h7};
        tv[12] = '{1,0,4'h0,32'h00,8'h00,1, 0,0,32'h00,8'h00,4'h7};
        tv[13] = '{1,1,4'h0,32'h00,8'h00,1, 1,0,32'h30,8'h40,4'h6};
        tv[14] = '{1,1,4'h0,32'h00,8'h00,1, 1,1,32'h30,8'h40,4'h4};
        tv[15] = '{1,1,4'h0,32'h00,8'h00,1, 1,2,32'h30,8'h40,4'h0};
        tv[16] = '{1,1,4'h0,32'h00,8'h00,1, 0,0,32'h00,8'h00,4'h0};
        tv[17] = '{1,0,4'h9,32'h50,8'h60,1, 0,0,32'h00,8'h00,4'h9};
        tv[18] = '{1,1,4'h0,32'h00,8'h00,0, 1,3,32'h50,8'h60,4'h1};
        tv[19] = '{1,1,4'h0,32'h00,8'h00,0, 1,3,32'h50,8'h60,4'h1};
        tv[20] = '{1,1,4'h0,32'h00,8'h00,1, 1,0,32'h50,8'h60,4'h0};
        tv[21] = '{1,1,4'h0,32'h00,8'h00,1, 0,0,32'h00,8'h00,4'h0};

        #2;
        for (int r = 0; r < 22; r++) begin
            drive(tv[r].rst, tv[r].en, tv[r].rv, tv[r].d, tv[r].idx, tv[r].rdy);
            step();
            chk($sformatf("vec%0d pending", r), 64'(pend), 64'(tv[r].e_pend));
            chk($sformatf("vec%0d put_valid", r), 64'(pvalid), 64'(tv[r].e_valid));
            chk($sformatf("vec%0d drop_cnt", r), 64'(dcnt), 64'd0);
            if (tv[r].e_valid) begin
                chk($sformatf("vec%0d put_src", r), 64'(psrc), 64'(tv[r].e_src));
                chk($sformatf("vec%0d put_data", r), 64'(pdata), 64'(tv[r].e_data));
                chk($sformatf("vec%0d put_sig_idx", r), 64'(psidx), 64'(tv[r].e_idx));
            end
        end

        // Backpressure with req 0 refreshed every cycle.
        drive(0, 1, '0, '0, '0, 0); step();
        drive(1, 1, 4'h1, 32'hA0, 8'h01, 0); step();
        first_val = 32'hA0;
        for (int p = 1; p < 5; p++) begin
            drive(1, 1, 4'h1, 32'hA0 + p, 8'h01 + p, 0); step();
            chk("bp valid", 64'(pvalid), 64'd1);
            chk("bp stable data", 64'(pdata), 64'(first_val));
        end
        drive(1, 1, '0, '0, '0, 0); step();
        chk("bp still stable", 64'(pdata), 64'(first_val));
        chk("bp drop_cnt", 64'(dcnt), 64'd3);
        drive(1, 1, '0, '0, '0, 1); step();
        chk("bp newest offered", 64'(pdata), 64'h A4);
        chk("bp newest idx", 64'(psidx), 64'h05);
        step();
        chk("bp idle after", 64'(pvalid), 64'd0);

        // Reset in the middle of an offer with req 2 waiting.
        drive(0, 1, '0, '0, '0, 0); step();
        drive(1, 1, 4'h5, 32'h77, 8'h33, 0); step();
        drive(1, 1, '0, '0, '0, 0); step();
        chk("mid offer valid", 64'(pvalid), 64'd1);
        chk("mid offer pending", 64'(pend), 64'h4);
        drive(0, 1, '0, '0, '0, 0); step();
        chk("rst outputs", 64'({pvalid, pend, psrc, pdata, psidx, dcnt}), 64'd0);
        for (int c = 0; c < 5; c++) begin
            drive(1, 1, '0, '0, '0, 1); step();
            chk("rst no put", 64'(pvalid), 64'd0);
        end

        // Saturation: 1 set plus 65540 overwrites with loads inhibited.
        drive(0, 1, '0, '0, '0, 0); step();
        for (int c = 0; c < 65541; c++) begin
            drive(1, 0, 4'h1, DW'(c), 8'h0, 0);
            step();
        end
        chk("sat drop_cnt", 64'(dcnt), 64'hFFFF);
        drive(1, 0, 4'h1, '0, '0, 0); step();
        chk("sat hold", 64'(dcnt), 64'hFFFF);

        // Randomised traffic against the model.
        drive(0, 1, '0, '0, '0, 0); step();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            en    = ($urandom_range(0, 7) != 0);
            rv    = N'($urandom) & N'($urandom);
            prdy  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                rdata[i*DW +: DW] = $urandom;
                ridx[i*SW +: SW]  = SW'($urandom);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
